// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and phase-sequencing helpers for the MIPS control path.
// Each instruction class walks a fixed phase list that ends at a class-specific last phase.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_MEM    = 3'd4,
        PH_WB     = 3'd5,
        PH_DUMMY  = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_LOAD   = 2'd2,
        CLS_STORE  = 2'd3
    } op_class_t;

    function automatic phase_t last_phase(input op_class_t cls);
        phase_t lp;
        case (cls)
            CLS_ALU:    lp = PH_DUMMY;
            CLS_BRANCH: lp = PH_EXEC;
            CLS_LOAD:   lp = PH_WB;
            CLS_STORE:  lp = PH_MEM;
            default:    lp = PH_DUMMY;
        endcase
        return lp;
    endfunction

    // Successor of a phase inside an instruction; the class's last phase wraps to FETCH.
    function automatic phase_t next_phase(input phase_t ph, input op_class_t cls);
        phase_t nxt;
        case (ph)
            PH_IDLE:   nxt = PH_FETCH;
            PH_FETCH:  nxt = PH_DECODE;
            PH_DECODE: nxt = PH_EXEC;
            PH_EXEC:   nxt = (cls == CLS_ALU)    ? PH_WB    :
                             (cls == CLS_BRANCH) ? PH_FETCH : PH_MEM;
            PH_MEM:    nxt = (cls == CLS_LOAD)   ? PH_WB    : PH_FETCH;
            PH_WB:     nxt = (cls == CLS_ALU)    ? PH_DUMMY : PH_FETCH;
            default:   nxt = PH_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running modulo-2^WIDTH counter that steps when inc is high.
// Synchronous active-high reset has priority over inc.
module wrap_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/machine_cycle_seq.sv
// Per-instruction-class phase sequencer with stall/flush/enable gating,
// per-instruction cycle counter, retired-instruction counter and sticky budget overrun.
module machine_cycle_seq
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH    = 4,
    parameter int MAX_CYCLES   = 12,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [1:0]              op_class,
    output logic [2:0]              phase,
    output logic [CNT_WIDTH-1:0]    counter,
    output logic                    last,
    output logic                    done,
    output logic [RETIRE_WIDTH-1:0] retired,
    output logic                    overrun
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam int unsigned          BUDGET  = MAX_CYCLES;

    phase_t                 ph_p0, ph_nxt;
    op_class_t              cls_p0, cls_nxt;
    logic [CNT_WIDTH-1:0]   cnt_p0, cnt_nxt;
    logic                   done_p0, done_nxt;
    logic                   ovr_p0, ovr_nxt;
    logic                   retire;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign last = (ph_p0 == last_phase(cls_p0));

    // next-state: flush > hold (enable low) > start from IDLE > stall > advance
    always_comb begin
        ph_nxt   = ph_p0;
        cls_nxt  = cls_p0;
        cnt_nxt  = cnt_p0;
        done_nxt = 1'b0;
        retire   = 1'b0;

        if (flush) begin
            if (enable) begin
                ph_nxt  = PH_FETCH;
                cnt_nxt = CNT_ONE;
            end else begin
                ph_nxt  = PH_IDLE;
                cnt_nxt = '0;
            end
        end else if (!enable) begin
            ph_nxt = ph_p0;
        end else if (ph_p0 == PH_IDLE) begin
            ph_nxt  = PH_FETCH;
            cnt_nxt = CNT_ONE;
        end else if (stall) begin
            cnt_nxt = sat_inc(cnt_p0);
        end else if (last) begin
            ph_nxt   = PH_FETCH;
            cnt_nxt  = CNT_ONE;
            done_nxt = 1'b1;
            retire   = 1'b1;
        end else begin
            ph_nxt  = next_phase(ph_p0, cls_p0);
            cnt_nxt = sat_inc(cnt_p0);
            if (ph_p0 == PH_DECODE) begin
                cls_nxt = op_class_t'(op_class);
            end
        end

        // Judged on the state being entered so the flag rises with the counter value itself.
        ovr_nxt = ovr_p0 |
                  ((32'(cnt_nxt) == BUDGET) && (ph_nxt != last_phase(cls_nxt)));
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            ph_p0   <= PH_IDLE;
            cls_p0  <= CLS_ALU;
            cnt_p0  <= '0;
            done_p0 <= 1'b0;
            ovr_p0  <= 1'b0;
        end else begin
            ph_p0   <= ph_nxt;
            cls_p0  <= cls_nxt;
            cnt_p0  <= cnt_nxt;
            done_p0 <= done_nxt;
            ovr_p0  <= ovr_nxt;
        end
    end

    wrap_counter #(
        .WIDTH (RETIRE_WIDTH)
    ) u_retired (
        .clk   (clk),
        .reset (reset),
        .inc   (retire),
        .count (retired)
    );

    assign phase   = ph_p0;
    assign counter = cnt_p0;
    assign done    = done_p0;
    assign overrun = ovr_p0;

endmodule

// File: tb/tb_machine_cycle_seq.sv
// Bench for machine_cycle_seq: two instances (default and MAX_CYCLES=6/RETIRE_WIDTH=2)
// driven in lockstep, checked every cycle against a phase-list model plus literal spot checks.
module tb_machine_cycle_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] op_class = 2'd0;

    logic [2:0]  ph_a, ph_b;
    logic [3:0]  cnt_a, cnt_b;
    logic        last_a, last_b, done_a, done_b, ovr_a, ovr_b;
    logic [15:0] ret_a;
    logic [1:0]  ret_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    machine_cycle_seq #(.CNT_WIDTH(4), .MAX_CYCLES(12), .RETIRE_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
        .op_class(op_class), .phase(ph_a), .counter(cnt_a), .last(last_a),
        .done(done_a), .retired(ret_a), .overrun(ovr_a));

    machine_cycle_seq #(.CNT_WIDTH(4), .MAX_CYCLES(6), .RETIRE_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
        .op_class(op_class), .phase(ph_b), .counter(cnt_b), .last(last_b),
        .done(done_b), .retired(ret_b), .overrun(ovr_b));

    // Model: instruction = index into its class's phase list.
    typedef struct {
        bit idle;
        int step;
        int cls;
        int cnt;
        int ret;
        bit ovr;
        bit dn;
    } mstate_t;

    mstate_t m [2];
    int max_cyc [2] = '{12, 6};
    int ret_mod [2] = '{65536, 4};
    int seq_len [4] = '{5, 3, 5, 4};
    int seq_tab [4][5] = '{'{1, 2, 3, 5, 6}, '{1, 2, 3, 0, 0}, '{1, 2, 3, 4, 5}, '{1, 2, 3, 4, 0}};

    function automatic int m_phase(input mstate_t s);
        return s.idle ? 0 : seq_tab[s.cls][s.step];
    endfunction

    function automatic int m_last(input mstate_t s);
        return (!s.idle && s.step == seq_len[s.cls] - 1) ? 1 : 0;
    endfunction

    function automatic int bump(input int c);
        return (c >= 15) ? 15 : c + 1;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input int idx, input bit rst,
                                           input bit en, input bit st, input bit fl, input int oc);
        mstate_t n;
        n = s;
        n.dn = 1'b0;
        if (rst) begin
            n.idle = 1'b1; n.step = 0; n.cls = 0; n.cnt = 0; n.ret = 0; n.ovr = 1'b0;
            return n;
        end
        if (fl) begin
            n.idle = !en; n.step = 0; n.cnt = en ? 1 : 0;
        end else if (!en) begin
            n.dn = 1'b0;
        end else if (s.idle) begin
            n.idle = 1'b0; n.step = 0; n.cnt = 1;
        end else if (st) begin
            n.cnt = bump(s.cnt);
        end else if (m_last(s) != 0) begin
            n.step = 0; n.cnt = 1; n.dn = 1'b1;
            n.ret = (s.ret + 1) % ret_mod[idx];
        end else begin
            if (s.step == 1) n.cls = oc;
            n.step = s.step + 1;
            n.cnt = bump(s.cnt);
        end
        if (n.cnt == max_cyc[idx] && m_last(n) == 0) n.ovr = 1'b1;
        return n;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            m[i] = model_step(m[i], i, reset, enable, stall, flush, int'(op_class));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("a_phase",   int'(ph_a),   m_phase(m[0]));
            chk("a_counter", int'(cnt_a),  m[0].cnt);
            chk("a_last",    int'(last_a), m_last(m[0]));
            chk("a_done",    int'(done_a), int'(m[0].dn));
            chk("a_retired", int'(ret_a),  m[0].ret);
            chk("a_overrun", int'(ovr_a),  int'(m[0].ovr));
            chk("b_phase",   int'(ph_b),   m_phase(m[1]));
            chk("b_counter", int'(cnt_b),  m[1].cnt);
            chk("b_last",    int'(last_b), m_last(m[1]));
            chk("b_done",    int'(done_b), int'(m[1].dn));
            chk("b_retired", int'(ret_b),  m[1].ret);
            chk("b_overrun", int'(ovr_b),  int'(m[1].ovr));
        end
    end

    task automatic tick(input int en, input int st, input int fl, input int oc);
        enable   = (en != 0);
        stall    = (st != 0);
        flush    = (fl != 0);
        op_class = 2'(oc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    int exp_ret_b [5] = '{1, 2, 3, 0, 1};

    initial begin
        reset = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        reset = 1'b0;
        armed = 1'b1;
        chk("rst_phase", int'(ph_a), 0);
        chk("rst_counter", int'(cnt_a), 0);
        chk("rst_outs", int'({last_a, done_a, ovr_a}), 0);
        chk("rst_retired", int'(ret_a), 0);
        tick(0, 0, 0, 0);
        chk("idle_hold", int'(ph_a), 0);

        // ALU: 1,2,3,5,6 then FETCH with done
        tick(1, 0, 0, 0);
        chk("alu_fetch", int'(ph_a), 1);
        chk("alu_cnt1", int'(cnt_a), 1);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        chk("alu_dummy", int'(ph_a), 6);
        chk("alu_cnt5", int'(cnt_a), 5);
        chk("alu_last", int'(last_a), 1);
        tick(1, 0, 0, 0);
        chk("alu_done_phase", int'(ph_a), 1);
        chk("alu_done", int'(done_a), 1);
        chk("alu_retired", int'(ret_a), 1);
        tick(1, 0, 0, 0);
        chk("alu_done_1cyc", int'(done_a), 0);

        // BRANCH, op_class noise outside the latching DECODE cycle
        do_reset();
        tick(1, 0, 0, 2);
        tick(1, 0, 0, 2);
        tick(1, 0, 0, 1);
        chk("br_exec_last", int'(last_a), 1);
        tick(1, 0, 0, 3);
        chk("br_done", int'(done_a), 1);
        chk("br_phase", int'(ph_a), 1);
        chk("br_retired", int'(ret_a), 1);

        // LOAD with two stall cycles in MEM
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 2);
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("ld_mem_held", int'(ph_a), 4);
        tick(1, 0, 0, 0);
        chk("ld_wb", int'(ph_a), 5);
        chk("ld_cnt7", int'(cnt_a), 7);
        tick(1, 0, 0, 0);
        chk("ld_done", int'(done_a), 1);
        chk("ld_ovr_a", int'(ovr_a), 0);
        chk("ld_ovr_b", int'(ovr_b), 1);

        // STORE flushed in EXEC, then completed
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 3);
        tick(1, 0, 1, 0);
        chk("st_flush_phase", int'(ph_a), 1);
        chk("st_flush_cnt", int'(cnt_a), 1);
        chk("st_flush_ret", int'(ret_a), 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 3);

        // ALU with 5 stalls in EXEC: budget 6 crossed in dut_b only
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        chk("ovr_before", int'(ovr_b), 0);
        tick(1, 1, 0, 0);
        chk("ovr_at6_cnt", int'(cnt_b), 6);
        chk("ovr_at6", int'(ovr_b), 1);
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        chk("ovr_sticky", int'(ovr_b), 1);
        chk("ovr_a_clear", int'(ovr_a), 0);
        do_reset();
        chk("ovr_reset", int'(ovr_b), 0);

        // Five branches with a 3-cycle enable freeze in DECODE of the second
        tick(1, 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            tick(1, 0, 0, 1);
            if (k == 1) begin
                for (int j = 0; j < 3; j++) tick(0, 0, 0, 0);
                chk("frz_phase", int'(ph_a), 2);
                chk("frz_cnt", int'(cnt_a), 2);
            end
            tick(1, 0, 0, 1);
            tick(1, 0, 0, 1);
            chk("wrap_ret_b", int'(ret_b), exp_ret_b[k]);
        end
        tick(0, 0, 0, 0);
        chk("en_low_done", int'(done_a), 0);

        // Corner events
        do_reset();
        tick(1, 1, 0, 0);
        chk("idle_stall_start", int'(ph_a), 1);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(1, 1, 0, 1);
        chk("stall_last_nodone", int'(done_a), 0);
        tick(1, 0, 1, 1);
        chk("flush_last_ret", int'(ret_a), 0);
        chk("flush_last_done", int'(done_a), 0);
        tick(0, 0, 1, 0);
        chk("flush_en0_idle", int'(ph_a), 0);
        tick(1, 0, 1, 0);
        chk("flush_idle_start", int'(ph_a), 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) tick(1, 1, 0, 0);
        chk("cnt_saturate", int'(cnt_a), 15);
        chk("sat_ovr_a", int'(ovr_a), 1);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
